coproc_arbiter: RTL and testbench
=================================

COPROC_ARBITER -- requirements
Module: coproc_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024: max clk cycles spent in ISSUE plus WAIT before abort.
REQ-002 Parameter MATRIX_W, default 200: packed 5x5 int8 matrix width.
REQ-003 clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  2  request per requester (bit0 = A, bit1 = B); held high until the matching ack.
REQ-006 instr  input  10  5-bit instruction per requester ({opcode[2:0], size[1:0]}); A in [4:0].
REQ-007 m1  input  400  operand matrix 1 per requester; A in [199:0].
REQ-008 m2  input  400  operand matrix 2 per requester; A in [199:0].
REQ-009 ack  output  2  one-cycle, one-hot pulse: operands latched for the granted requester.
REQ-010 cu_instruction  output  5  instruction to the matrix control unit.
REQ-011 cu_matrix1, cu_matrix2  output  200 each  operands to the control unit.
REQ-012 cu_start  output  1  start request to the control unit.
REQ-013 cu_ready  input  1  control unit idle/result-ready.
REQ-014 cu_result  input  200  control unit result matrix.
REQ-015 cu_overflow  input  1  control unit overflow flag.
REQ-016 res  output  200  captured result; res_ovf  output  1  captured overflow.
REQ-017 done  output  2  one-cycle, one-hot completion pulse to the owning requester.
REQ-018 err  output  1  high together with done when the operation timed out.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states are IDLE, ISSUE, WAIT, DONE and ERR.
REQ-021 IDLE: when req != 0 and cu_ready = 1, the block grants, latches that requester's instr/m1/m2 into the cu_* registers, pulses ack[g] on the next cycle, and goes to ISSUE.
REQ-022 IDLE with cu_ready = 0: no grant is made and the FSM stays in IDLE.
REQ-023 Arbitration is round-robin: with both requests high, the grant goes to the requester not served last; the pointer after reset favours A.
REQ-024 A single active request is granted regardless of the pointer.
REQ-025 The pointer updates only on transition into DONE or ERR.
REQ-026 ISSUE: cu_start = 1; when cu_ready is sampled 0, cu_start drops the same edge and the FSM goes to WAIT.
REQ-027 cu_start is held because the control unit runs on a divided clock; a single-cycle pulse is forbidden.
REQ-028 WAIT: cu_start = 0; when cu_ready = 1, res <= cu_result, res_ovf <= cu_overflow, and the FSM goes to DONE.
REQ-029 DONE: done[g] = 1 for exactly one cycle, then the FSM goes to IDLE.
REQ-030 A new grant is possible no earlier than the cycle after DONE.
REQ-031 Timeout counter: cleared on entry to ISSUE, incremented in ISSUE/WAIT; reaching TIMEOUT goes to ERR.
REQ-032 ERR: cu_start = 0, res = 0, res_ovf = 0, done[g] = 1 and err = 1 for one cycle, then IDLE.
REQ-033 res/res_ovf hold their value until the next capture or ERR.
REQ-034 cu_* operand registers are stable from ISSUE entry until DONE/ERR.
REQ-035 A request arriving while busy waits, never drops, and is served after the current operation.
REQ-036 At most one bit of ack or done is ever high.

Reset
REQ-037 On rst, the FSM goes to IDLE, the pointer selects A, and the counter clears.
REQ-038 On rst, every output is 0: ack, done, err, busy, cu_start, cu_instruction, cu_matrix1/2, res, res_ovf.
REQ-039 rst mid-operation (ISSUE/WAIT) aborts without any done pulse; the control unit shares rst.

Structure
REQ-040 Shared package coproc_pkg holds MATRIX_W, INSTR_W = 5, the opcode/size constants, and the arbiter state encoding.
REQ-041 Sub-module rr_arbiter_2 holds the combinational grant and the registered pointer; the FSM, counter and datapath registers stay in coproc_arbiter.

Verification
REQ-042 Single request: req = 01, instr = 5'b00011 (add 5x5), m1 = m2 = all 8'h01, cu model -> ack = 01 once; cu_start held until cu_ready falls; done = 01 with res = all 8'h02, res_ovf = 0.
REQ-043 Contention: req = 11 held from reset -> serving order A, B, A, B over four operations; done matches the ack owner each time.
REQ-044 Overflow path: cu model returns cu_overflow = 1 -> res_ovf = 1 with done; the next operation with no overflow clears res_ovf.
REQ-045 Timeout: TIMEOUT = 16, cu_ready never falls -> ERR after 16 cycles; done[g] = 1, err = 1, res = 0; FSM back in IDLE, next request served.
REQ-046 Reset in WAIT: rst asserted -> no done pulse; all outputs 0 next cycle; pointer favours A.
REQ-047 cu_ready = 0 at request time -> no ack until cu_ready = 1; ack follows one cycle later.

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared types and constants for the matrix coprocessor front end.
package coproc_pkg;

    localparam int unsigned MATRIX_W = 200;
    localparam int unsigned INSTR_W  = 5;

    // instr = {opcode, size}
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_TRANS = 3'b011;
    localparam logic [2:0] OP_SCALE = 3'b100;

    localparam logic [1:0] SIZE_2X2 = 2'b00;
    localparam logic [1:0] SIZE_3X3 = 2'b01;
    localparam logic [1:0] SIZE_4X4 = 2'b10;
    localparam logic [1:0] SIZE_5X5 = 2'b11;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StWait  = 3'd2,
        StDone  = 3'd3,
        StErr   = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant with a registered priority pointer.
module rr_arbiter_2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       served_b_i,
    output logic [1:0] grant_o
);

    // prio_q = 0 favours A, 1 favours B
    logic prio_q, prio_d;

    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = prio_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

    always_comb begin
        prio_d = prio_q;
        if (update_i) begin
            prio_d = ~served_b_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/coproc_arbiter.sv
// Arbitrates two requesters onto one matrix control unit and returns its result.
module coproc_arbiter
    import coproc_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned MATRIX_W = coproc_pkg::MATRIX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [2*INSTR_W-1:0]  instr,
    input  logic [2*MATRIX_W-1:0] m1,
    input  logic [2*MATRIX_W-1:0] m2,
    output logic [1:0]            ack,
    output logic [INSTR_W-1:0]    cu_instruction,
    output logic [MATRIX_W-1:0]   cu_matrix1,
    output logic [MATRIX_W-1:0]   cu_matrix2,
    output logic                  cu_start,
    input  logic                  cu_ready,
    input  logic [MATRIX_W-1:0]   cu_result,
    input  logic                  cu_overflow,
    output logic [MATRIX_W-1:0]   res,
    output logic                  res_ovf,
    output logic [1:0]            done,
    output logic                  err,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    arb_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [1:0]           ack_q, ack_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [MATRIX_W-1:0]  mat1_q, mat1_d;
    logic [MATRIX_W-1:0]  mat2_q, mat2_d;
    logic [MATRIX_W-1:0]  res_q, res_d;
    logic                 ovf_q, ovf_d;
    logic [1:0]           grant;
    logic                 arb_update;
    logic                 timed_out;

    rr_arbiter_2 u_rr (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .update_i   (arb_update),
        .served_b_i (owner_q),
        .grant_o    (grant)
    );

    // cnt_q holds the number of ISSUE/WAIT cycles already completed
    assign timed_out = (cnt_q >= CntW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        ack_d      = 2'b00;
        instr_d    = instr_q;
        mat1_d     = mat1_q;
        mat2_d     = mat2_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        arb_update = 1'b0;
        unique case (state_q)
            StIdle: begin
                if ((req != 2'b00) && cu_ready) begin
                    state_d = StIssue;
                    owner_d = grant[1];
                    ack_d   = grant;
                    cnt_d   = '0;
                    instr_d = grant[1] ? instr[2*INSTR_W-1:INSTR_W] : instr[INSTR_W-1:0];
                    mat1_d  = grant[1] ? m1[2*MATRIX_W-1:MATRIX_W] : m1[MATRIX_W-1:0];
                    mat2_d  = grant[1] ? m2[2*MATRIX_W-1:MATRIX_W] : m2[MATRIX_W-1:0];
                end
            end
            StIssue: begin
                cnt_d = cnt_q + CntW'(1);
                if (!cu_ready) begin
                    state_d = StWait;
                end else if (timed_out) begin
                    state_d    = StErr;
                    res_d      = '0;
                    ovf_d      = 1'b0;
                    arb_update = 1'b1;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (cu_ready) begin
                    state_d    = StDone;
                    res_d      = cu_result;
                    ovf_d      = cu_overflow;
                    arb_update = 1'b1;
                end else if (timed_out) begin
                    state_d    = StErr;
                    res_d      = '0;
                    ovf_d      = 1'b0;
                    arb_update = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= 2'b00;
            instr_q <= '0;
            mat1_q  <= '0;
            mat2_q  <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            instr_q <= instr_d;
            mat1_q  <= mat1_d;
            mat2_q  <= mat2_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ack            = ack_q;
    assign cu_instruction = instr_q;
    assign cu_matrix1     = mat1_q;
    assign cu_matrix2     = mat2_q;
    assign res            = res_q;
    assign res_ovf        = ovf_q;
    assign busy           = (state_q != StIdle);
    assign cu_start       = (state_q == StIssue);
    assign err            = (state_q == StErr);
    assign done           = ((state_q == StDone) || (state_q == StErr)) ?
                            (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_coproc_arbiter.sv
// Directed bench for coproc_arbiter with a small behavioural control-unit model.
module tb_coproc_arbiter;

    localparam int unsigned MW = 200;

    localparam logic [MW-1:0] ONES   = {25{8'h01}};
    localparam logic [MW-1:0] TWOS   = {25{8'h02}};
    localparam logic [MW-1:0] THREES = {25{8'h03}};
    localparam logic [MW-1:0] FOURS  = {25{8'h04}};
    localparam logic [MW-1:0] SEVENS = {25{8'h07}};

    logic          clk;
    logic          rst;
    logic [1:0]    req;
    logic [9:0]    instr;
    logic [2*MW-1:0] m1, m2;
    logic [1:0]    ack;
    logic [4:0]    cu_instruction;
    logic [MW-1:0] cu_matrix1, cu_matrix2;
    logic          cu_start;
    logic          cu_ready;
    logic [MW-1:0] cu_result;
    logic          cu_overflow;
    logic [MW-1:0] res;
    logic          res_ovf;
    logic [1:0]    done;
    logic          err;
    logic          busy;

    int n_cmp;
    int n_fail;

    // control-unit model controls
    logic stall, hang, ovf_mode;
    logic mdl_ready;
    logic [1:0] mph;
    logic [3:0] mcnt;

    coproc_arbiter #(
        .TIMEOUT  (16),
        .MATRIX_W (MW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .instr          (instr),
        .m1             (m1),
        .m2             (m2),
        .ack            (ack),
        .cu_instruction (cu_instruction),
        .cu_matrix1     (cu_matrix1),
        .cu_matrix2     (cu_matrix2),
        .cu_start       (cu_start),
        .cu_ready       (cu_ready),
        .cu_result      (cu_result),
        .cu_overflow    (cu_overflow),
        .res            (res),
        .res_ovf        (res_ovf),
        .done           (done),
        .err            (err),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [MW-1:0] madd(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] r;
        for (int i = 0; i < 25; i++) r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
        return r;
    endfunction

    // CU model: sees start, drops ready a cycle later, adds after a few cycles.
    assign cu_ready = mdl_ready & ~stall;

    always @(posedge clk) begin
        if (rst) begin
            mph         <= 2'd0;
            mcnt        <= 4'd0;
            mdl_ready   <= 1'b1;
            cu_result   <= '0;
            cu_overflow <= 1'b0;
        end else begin
            case (mph)
                2'd0: if (cu_start && !hang) mph <= 2'd1;
                2'd1: begin
                    mdl_ready <= 1'b0;
                    mcnt      <= 4'd3;
                    mph       <= 2'd2;
                end
                2'd2: begin
                    if (mcnt == 4'd0) begin
                        cu_result   <= madd(cu_matrix1, cu_matrix2);
                        cu_overflow <= ovf_mode;
                        mdl_ready   <= 1'b1;
                        mph         <= 2'd3;
                    end else begin
                        mcnt <= mcnt - 4'd1;
                    end
                end
                default: mph <= 2'd0;
            endcase
        end
    end

    task automatic wait_ack(output logic [1:0] a, output int cyc);
        a   = 2'b00;
        cyc = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                a   = ack;
                cyc = i;
                break;
            end
        end
    endtask

    // Counts cu_start-high negedges (current one included) and extra ack pulses.
    task automatic wait_done(output logic [1:0] d, output logic e, output int cyc,
                             output int starts, output int ackx);
        d      = 2'b00;
        e      = 1'b0;
        cyc    = -1;
        starts = cu_start ? 1 : 0;
        ackx   = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (cu_start) starts++;
            if (ack != 2'b00) ackx++;
            if (done != 2'b00) begin
                d   = done;
                e   = err;
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b00;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ack, done, err, busy, cu_start, res_ovf} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000000", {ack, done, err, busy, cu_start, res_ovf});
        end
        n_cmp++;
        if (cu_instruction !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_instr: got %h want 0", cu_instruction);
        end
        n_cmp++;
        if ((cu_matrix1 | cu_matrix2) !== '0) begin
            n_fail++;
            $display("FAIL reset_matrix: got %h / %h want 0", cu_matrix1, cu_matrix2);
        end
        n_cmp++;
        if (res !== '0) begin
            n_fail++;
            $display("FAIL reset_res: got %h want 0", res);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [1:0] a, d;
        logic e;
        int c, s, ax;
        req = 2'b01;
        wait_ack(a, c);
        n_cmp++;
        if (a !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ack: got %b want 01", a);
        end
        n_cmp++;
        if (cu_instruction !== 5'b00011 || cu_matrix1 !== ONES || cu_matrix2 !== ONES) begin
            n_fail++;
            $display("FAIL single_operands: got instr %b m1 %h", cu_instruction, cu_matrix1);
        end
        req = 2'b00;
        wait_done(d, e, c, s, ax);
        n_cmp++;
        if (d !== 2'b01 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got done %b err %b want 01 0", d, e);
        end
        n_cmp++;
        if (s !== 3) begin
            n_fail++;
            $display("FAIL single_start_hold: got %0d cycles want 3", s);
        end
        n_cmp++;
        if (ax !== 0) begin
            n_fail++;
            $display("FAIL single_ack_width: got %0d extra ack cycles want 0", ax);
        end
        n_cmp++;
        if (res !== TWOS || res_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL single_res: got %h ovf %b want all 02 ovf 0", res, res_ovf);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 2'b00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after_done: got done %b busy %b want 00 0", done, busy);
        end
    endtask

    task automatic test_contention();
        logic [1:0] a, d, exp_g;
        logic e;
        int c, s, ax;
        rst = 1'b1;
        req = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_ack(a, c);
            n_cmp++;
            if (a !== exp_g) begin
                n_fail++;
                $display("FAIL contention_ack%0d: got %b want %b", k, a, exp_g);
            end
            wait_done(d, e, c, s, ax);
            n_cmp++;
            if (d !== exp_g || res !== ((exp_g == 2'b01) ? TWOS : SEVENS)) begin
                n_fail++;
                $display("FAIL contention_done%0d: got %b res %h want %b", k, d, res, exp_g);
            end
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [1:0] a, d;
        logic e;
        int c, s, ax;
        ovf_mode = 1'b1;
        req = 2'b01;
        wait_ack(a, c);
        req = 2'b00;
        wait_done(d, e, c, s, ax);
        n_cmp++;
        if (d !== 2'b01 || res_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got done %b ovf %b want 01 1", d, res_ovf);
        end
        ovf_mode = 1'b0;
        req = 2'b10;
        wait_ack(a, c);
        n_cmp++;
        if (a !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_next_ack: got %b want 10", a);
        end
        req = 2'b00;
        wait_done(d, e, c, s, ax);
        n_cmp++;
        if (d !== 2'b10 || res_ovf !== 1'b0 || res !== SEVENS) begin
            n_fail++;
            $display("FAIL ovf_clear: got done %b ovf %b res %h want 10 0 all 07", d, res_ovf, res);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] a, d;
        logic e;
        int c, s, ax;
        hang = 1'b1;
        req = 2'b01;
        wait_ack(a, c);
        req = 2'b00;
        wait_done(d, e, c, s, ax);
        n_cmp++;
        if (d !== 2'b01 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_done: got done %b err %b want 01 1", d, e);
        end
        n_cmp++;
        if (c !== 16 || s !== 16) begin
            n_fail++;
            $display("FAIL timeout_cycles: got %0d (start %0d) want 16", c, s);
        end
        n_cmp++;
        if (res !== '0 || res_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_res: got %h ovf %b want 0 0", res, res_ovf);
        end
        hang = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || err !== 1'b0 || done !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_idle: got busy %b err %b done %b want 0 0 00", busy, err, done);
        end
        req = 2'b01;
        wait_ack(a, c);
        req = 2'b00;
        wait_done(d, e, c, s, ax);
        n_cmp++;
        if (a !== 2'b01 || d !== 2'b01 || e !== 1'b0 || res !== TWOS) begin
            n_fail++;
            $display("FAIL timeout_recover: got ack %b done %b err %b want 01 01 0", a, d, e);
        end
    endtask

    task automatic test_stall();
        logic [1:0] a, d;
        logic e;
        int c, s, ax, seen;
        stall = 1'b1;
        req = 2'b01;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack != 2'b00 || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL stall_no_grant: got %0d active cycles want 0", seen);
        end
        stall = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ack !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_ack_latency: got %b want 01", ack);
        end
        req = 2'b00;
        wait_done(d, e, c, s, ax);
        n_cmp++;
        if (d !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_done: got %b want 01", d);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [1:0] a, d;
        logic e, found;
        int c, s, ax;
        req = 2'b10;
        wait_ack(a, c);
        n_cmp++;
        if (a !== 2'b10) begin
            n_fail++;
            $display("FAIL rstwait_ack: got %b want 10", a);
        end
        req = 2'b00;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy && !cu_start) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL rstwait_reach_wait: got %b want 1", found);
        end
        rst = 1'b1;
        req = 2'b11;
        @(negedge clk);
        n_cmp++;
        if ({ack, done, err, busy, cu_start, res_ovf} !== 8'h00 || res !== '0 ||
            cu_instruction !== 5'b0 || cu_matrix1 !== '0) begin
            n_fail++;
            $display("FAIL rstwait_outputs: got ctrl %b res %h want 0",
                     {ack, done, err, busy, cu_start, res_ovf}, res);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ack !== 2'b01) begin
            n_fail++;
            $display("FAIL rstwait_pointer: got %b want 01", ack);
        end
        req = 2'b00;
        wait_done(d, e, c, s, ax);
        n_cmp++;
        if (d !== 2'b01 || res !== TWOS) begin
            n_fail++;
            $display("FAIL rstwait_after: got done %b res %h want 01 all 02", d, res);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = 2'b00;
        stall    = 1'b0;
        hang     = 1'b0;
        ovf_mode = 1'b0;
        instr    = {5'b00010, 5'b00011};
        m1       = {THREES, ONES};
        m2       = {FOURS, ONES};
        test_reset();
        test_single();
        test_contention();
        test_overflow();
        test_timeout();
        test_stall();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
